// File: rtl/fetch_queue_pkg.sv
// Shared types for the prefetching fetch stage: word types, queue entry layout
// and the byte stride between consecutive instructions.
package fetch_queue_pkg;

  typedef logic [31:0] word_st;
  typedef logic [31:0] word_32ut;

  typedef struct packed {
    word_st   pc;
    word_32ut instr;
  } fetch_entry_st;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous circular FIFO holding fetched {pc, instr} entries; owns all
// queue storage and pointer wrap logic. Clear empties it in one cycle.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_st
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  entry_t                       i_data,
  input  logic                         i_pop,
  output entry_t                       o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= nextPtr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= nextPtr(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues in-order requests to a variable-latency
// instruction memory, buffers responses and presents a registered head to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned ILEN            = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_init_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_4_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic            r_valid;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_next4;

  logic            w_req;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_push;
  logic            w_load_out;
  logic            w_fifo_pop;
  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_occupancy;
  logic [CW:0]     w_credit_used;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  entry_t          w_head;
  entry_t          w_push_data;
  logic            w_unused;

  // Occupancy includes the output register so a response always finds space.
  assign w_occupancy   = w_fifo_count + CW'(r_valid);
  assign w_credit_used = {1'b0, w_occupancy} + {1'b0, r_outstanding};
  assign w_req         = rst_ni && !redirect_i
                         && (r_outstanding < CW'(MAX_OUTSTANDING))
                         && (w_credit_used < (CW + 1)'(DEPTH));
  assign w_gnt         = w_req && imem_gnt_i;
  assign w_rsp         = imem_rvalid_i && (r_outstanding != '0);
  assign w_push        = w_rsp && (r_discard == '0) && !redirect_i;
  assign w_load_out    = !r_valid || instr_ready_i;
  assign w_fifo_pop    = w_load_out && !w_fifo_empty && !redirect_i;
  assign w_push_data   = '{pc: r_rsp_pc, instr: imem_rdata_i};
  assign w_unused      = ^{redirect_pc_i[1:0], w_fifo_full};

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc;
  assign pc_next_4_o   = r_pc_next4;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (redirect_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_fifo_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // Redirect drops whatever is still in flight by converting it into discard credits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fetch_pc    <= pc_init_i;
      r_rsp_pc      <= pc_init_i;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_pc_next4    <= '0;
    end else if (redirect_i) begin
      r_fetch_pc    <= {redirect_pc_i[XLEN-1:2], 2'b00};
      r_rsp_pc      <= {redirect_pc_i[XLEN-1:2], 2'b00};
      r_outstanding <= r_outstanding - CW'(w_rsp);
      r_discard     <= r_outstanding - CW'(w_rsp);
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_pc_next4    <= '0;
    end else begin
      if (w_gnt) r_fetch_pc <= r_fetch_pc + STEP;
      if (w_push) r_rsp_pc <= r_rsp_pc + STEP;
      r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_rsp);
      if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      if (w_load_out) begin
        r_valid    <= !w_fifo_empty;
        r_instr    <= w_fifo_empty ? '0 : w_head.instr;
        r_pc       <= w_fifo_empty ? '0 : w_head.pc;
        r_pc_next4 <= w_fifo_empty ? '0 : w_head.pc + STEP;
      end
    end
  end

  property p_rvalid_has_credit;
    @(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> (r_outstanding != '0);
  endproperty
  a_rvalid_has_credit: assert property (p_rvalid_has_credit);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-order, fixed-latency memory model;
// each scenario task drives stimulus and checks against hand-computed values.
module tb_fetch_queue;

  logic        clk;
  logic        rst_ni;
  logic [31:0] pc_init_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_next_4_o;

  int total = 0;
  int bad = 0;

  int memLat = 1;
  bit memEn = 0;
  int edgeCnt = 0;
  logic [31:0] pendAddr[$];
  int          pendEdge[$];

  logic [31:0] grantLog[$];
  logic [31:0] popPc[$];
  logic [31:0] popInstr[$];
  logic [31:0] popNext[$];

  fetch_queue dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .pc_init_i     (pc_init_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_next_4_o   (pc_next_4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt++;

  // Memory decides its next-edge outputs shortly after each falling edge;
  // every request is granted and answered memLat edges later, with data ~addr.
  always @(negedge clk) begin
    #2;
    if (!memEn) begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      pendAddr.delete();
      pendEdge.delete();
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      if (pendAddr.size() > 0 && pendEdge[0] <= edgeCnt + 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = ~pendAddr[0];
        void'(pendAddr.pop_front());
        void'(pendEdge.pop_front());
      end
      imem_gnt_i = 1'b1;
      if (imem_req_o) begin
        pendAddr.push_back(imem_addr_o);
        pendEdge.push_back(edgeCnt + 1 + memLat);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_ni && imem_req_o && imem_gnt_i) grantLog.push_back(imem_addr_o);
    if (rst_ni && instr_valid_o && instr_ready_i) begin
      popPc.push_back(pc_o);
      popInstr.push_back(instr_o);
      popNext.push_back(pc_next_4_o);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic holdReset(input logic [31:0] pcInit);
    @(negedge clk);
    rst_ni     = 1'b0;
    memEn      = 1'b0;
    redirect_i = 1'b0;
    pc_init_i  = pcInit;
    repeat (2) @(negedge clk);
  endtask

  task automatic releaseReset(input int lat);
    memLat = lat;
    grantLog.delete();
    popPc.delete();
    popInstr.delete();
    popNext.delete();
    rst_ni = 1'b1;
    memEn  = 1'b1;
  endtask

  task automatic test_reset();
    holdReset(32'h0000_1000);
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req_o); end
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid_o); end
    total++; if (instr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 0", instr_o); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_o); end
    total++; if (pc_next_4_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc_next4: got %h expected 0", pc_next_4_o); end
  endtask

  task automatic test_stream();
    instr_ready_i = 1'b1;
    releaseReset(1);
    waitCycles(12);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (grantLog.size() <= i) begin bad++; $display("[TB] FAIL stream_grant%0d: got none expected %h", i, 32'h1000 + 4 * i); end
      else if (grantLog[i] !== 32'h1000 + 4 * i) begin bad++; $display("[TB] FAIL stream_grant%0d: got %h expected %h", i, grantLog[i], 32'h1000 + 4 * i); end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (popPc.size() <= i) begin bad++; $display("[TB] FAIL stream_pop%0d: got none expected %h", i, 32'h1000 + 4 * i); end
      else begin
        if (popPc[i] !== 32'h1000 + 4 * i) begin bad++; $display("[TB] FAIL stream_pc%0d: got %h expected %h", i, popPc[i], 32'h1000 + 4 * i); end
        total++; if (popInstr[i] !== ~(32'h1000 + 4 * i)) begin bad++; $display("[TB] FAIL stream_instr%0d: got %h expected %h", i, popInstr[i], ~(32'h1000 + 4 * i)); end
        total++; if (popNext[i] !== 32'h1004 + 4 * i) begin bad++; $display("[TB] FAIL stream_next%0d: got %h expected %h", i, popNext[i], 32'h1004 + 4 * i); end
      end
    end
  endtask

  task automatic test_stall();
    holdReset(32'h0000_1000);
    instr_ready_i = 1'b0;
    releaseReset(1);
    waitCycles(12);
    total++; if (grantLog.size() !== 4) begin bad++; $display("[TB] FAIL stall_grants: got %0d expected 4", grantLog.size()); end
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL stall_req: got %b expected 0", imem_req_o); end
    total++; if (instr_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid: got %b expected 1", instr_valid_o); end
    total++; if (pc_o !== 32'h1000) begin bad++; $display("[TB] FAIL stall_pc: got %h expected 00001000", pc_o); end
    total++; if (instr_o !== ~32'h1000) begin bad++; $display("[TB] FAIL stall_instr: got %h expected %h", instr_o, ~32'h1000); end
    total++; if (popPc.size() !== 0) begin bad++; $display("[TB] FAIL stall_no_pop: got %0d expected 0", popPc.size()); end
    instr_ready_i = 1'b1;
    waitCycles(12);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (popPc.size() <= i) begin bad++; $display("[TB] FAIL drain_pop%0d: got none expected %h", i, 32'h1000 + 4 * i); end
      else if (popPc[i] !== 32'h1000 + 4 * i) begin bad++; $display("[TB] FAIL drain_pc%0d: got %h expected %h", i, popPc[i], 32'h1000 + 4 * i); end
    end
  endtask

  task automatic test_redirect_latency();
    int n0;
    int stale;
    holdReset(32'h0000_1000);
    instr_ready_i = 1'b1;
    releaseReset(3);
    waitCycles(2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2002;
    n0 = grantLog.size();
    total++; if (n0 !== 2) begin bad++; $display("[TB] FAIL redir_inflight: got %0d expected 2", n0); end
    waitCycles(1);
    redirect_i = 1'b0;
    popPc.delete();
    popInstr.delete();
    waitCycles(20);
    total++;
    if (grantLog.size() <= n0) begin bad++; $display("[TB] FAIL redir_new_addr: got none expected 00002000"); end
    else if (grantLog[n0] !== 32'h2000) begin bad++; $display("[TB] FAIL redir_new_addr: got %h expected 00002000", grantLog[n0]); end
    total++;
    if (popPc.size() == 0) begin bad++; $display("[TB] FAIL redir_first_pc: got none expected 00002000"); end
    else begin
      if (popPc[0] !== 32'h2000) begin bad++; $display("[TB] FAIL redir_first_pc: got %h expected 00002000", popPc[0]); end
      total++; if (popInstr[0] !== ~32'h2000) begin bad++; $display("[TB] FAIL redir_first_instr: got %h expected %h", popInstr[0], ~32'h2000); end
    end
    stale = 0;
    foreach (popPc[i]) if (popPc[i][31:12] == 20'h00001) stale++;
    total++; if (stale !== 0) begin bad++; $display("[TB] FAIL redir_stale_pcs: got %0d expected 0", stale); end
  endtask

  task automatic test_redirect_rvalid();
    holdReset(32'h0000_1000);
    instr_ready_i = 1'b1;
    releaseReset(3);
    waitCycles(3);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_3000;
    waitCycles(1);
    redirect_i = 1'b0;
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rvredir_valid: got %b expected 0", instr_valid_o); end
    popPc.delete();
    popInstr.delete();
    waitCycles(20);
    total++;
    if (popPc.size() < 2) begin bad++; $display("[TB] FAIL rvredir_pops: got %0d expected >=2", popPc.size()); end
    else begin
      if (popPc[0] !== 32'h3000) begin bad++; $display("[TB] FAIL rvredir_pc0: got %h expected 00003000", popPc[0]); end
      total++; if (popInstr[0] !== ~32'h3000) begin bad++; $display("[TB] FAIL rvredir_instr0: got %h expected %h", popInstr[0], ~32'h3000); end
      total++; if (popPc[1] !== 32'h3004) begin bad++; $display("[TB] FAIL rvredir_pc1: got %h expected 00003004", popPc[1]); end
    end
  endtask

  task automatic test_redirect_full();
    holdReset(32'h0000_1000);
    instr_ready_i = 1'b0;
    releaseReset(1);
    waitCycles(10);
    total++; if (instr_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL full_valid_before: got %b expected 1", instr_valid_o); end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_4000;
    #3;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL full_redir_req: got %b expected 0", imem_req_o); end
    waitCycles(1);
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL full_redir_valid: got %b expected 0", instr_valid_o); end
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    popPc.delete();
    waitCycles(12);
    total++;
    if (popPc.size() == 0) begin bad++; $display("[TB] FAIL full_redir_pc: got none expected 00004000"); end
    else if (popPc[0] !== 32'h4000) begin bad++; $display("[TB] FAIL full_redir_pc: got %h expected 00004000", popPc[0]); end
  endtask

  task automatic test_wrap();
    logic [31:0] expAddr [3];
    expAddr[0] = 32'hFFFF_FFF8;
    expAddr[1] = 32'hFFFF_FFFC;
    expAddr[2] = 32'h0000_0000;
    holdReset(32'hFFFF_FFF8);
    instr_ready_i = 1'b1;
    releaseReset(1);
    waitCycles(12);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (grantLog.size() <= i) begin bad++; $display("[TB] FAIL wrap_grant%0d: got none expected %h", i, expAddr[i]); end
      else if (grantLog[i] !== expAddr[i]) begin bad++; $display("[TB] FAIL wrap_grant%0d: got %h expected %h", i, grantLog[i], expAddr[i]); end
    end
    total++;
    if (popPc.size() < 2) begin bad++; $display("[TB] FAIL wrap_pops: got %0d expected >=2", popPc.size()); end
    else begin
      if (popPc[1] !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pc1: got %h expected fffffffc", popPc[1]); end
      total++; if (popNext[1] !== 32'h0) begin bad++; $display("[TB] FAIL wrap_next1: got %h expected 00000000", popNext[1]); end
    end
  endtask

  task automatic test_reset_mid();
    holdReset(32'h0000_1000);
    instr_ready_i = 1'b1;
    releaseReset(1);
    waitCycles(6);
    rst_ni        = 1'b0;
    memEn         = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_5000;
    waitCycles(1);
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_req: got %b expected 0", imem_req_o); end
    total++; if (instr_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b expected 0", instr_valid_o); end
    total++; if (instr_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_instr: got %h expected 0", instr_o); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_pc: got %h expected 0", pc_o); end
    total++; if (pc_next_4_o !== 32'h0) begin bad++; $display("[TB] FAIL midrst_next4: got %h expected 0", pc_next_4_o); end
    redirect_i = 1'b0;
    releaseReset(1);
    waitCycles(10);
    total++;
    if (grantLog.size() == 0) begin bad++; $display("[TB] FAIL midrst_restart_addr: got none expected 00001000"); end
    else if (grantLog[0] !== 32'h1000) begin bad++; $display("[TB] FAIL midrst_restart_addr: got %h expected 00001000", grantLog[0]); end
    total++;
    if (popPc.size() == 0) begin bad++; $display("[TB] FAIL midrst_restart_pc: got none expected 00001000"); end
    else if (popPc[0] !== 32'h1000) begin bad++; $display("[TB] FAIL midrst_restart_pc: got %h expected 00001000", popPc[0]); end
  endtask

  initial begin
    rst_ni        = 1'b0;
    pc_init_i     = 32'h0000_1000;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_rvalid();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised successor to the single-cycle fetch stage. It decouples PC generation from decode with a prefetch FIFO. It issues in-order requests to an instruction memory that has variable latency, using a req/gnt/rvalid handshake, and allows several requests in flight. On a branch or jump redirect it flushes all queued and in-flight instructions. It sits between the PC logic and the decode stage of the pipelined core, replacing the fixed fetch register.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, queue entries (>=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered requests (1..DEPTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
pc_init_i  in  XLEN  PC loaded at reset
redirect_i  in  1  branch/jump taken; flush and restart
redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0
imem_req_o  out  1  request valid
imem_addr_o  out  XLEN  request address, 4-aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (in request order)
imem_rdata_i  in  ILEN  response instruction
instr_valid_o  out  1  queue head valid
instr_ready_i  in  1  decode accepts head (low = stall)
instr_o  out  ILEN  head instruction
pc_o  out  XLEN  head PC
pc_next_4_o  out  XLEN  pc_o + 4

Behaviour:
- Reset (rst_ni low at clk edge): fetch_pc = rsp_pc = pc_init_i; queue empty; outstanding = discard = 0.
- Reset outputs: imem_req_o = 0, instr_valid_o = 0, instr_o / pc_o / pc_next_4_o = 0.
- Reset mid-operation overrides everything, including redirect_i. Responses still in flight after reset are the memory's responsibility; the bench idles memory across reset.
- Issue: imem_req_o = !redirect_i && outstanding < MAX_OUTSTANDING && (count + outstanding) < DEPTH.
  - imem_addr_o = fetch_pc.
  - req && gnt: fetch_pc += 4, outstanding++.
  - While req is high without gnt, the address stays stable. req is only withdrawn by redirect.
- Credit rule: count + outstanding <= DEPTH at all times, so a response can never meet a full queue.
- Response: imem_rvalid_i decrements outstanding.
  - If discard > 0: the data is dropped and discard decrements.
  - Otherwise push {rsp_pc, imem_rdata_i} and rsp_pc += 4.
  - Grant and response in the same cycle: outstanding is unchanged.
- Output: the head is registered from queue storage. A response at edge N is visible on instr_valid_o after edge N+1 (1-cycle latency); there is no bypass.
  - Pop on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle are both performed and count is unchanged.
  - With instr_ready_i low, outputs hold stable.
- Redirect (redirect_i high, rst_ni high):
  - Queue cleared; instr_valid_o = 0 next cycle.
  - fetch_pc = rsp_pc = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - discard = outstanding - rvalid (value after this cycle), so a same-cycle response is dropped.
  - imem_req_o = 0 this cycle. Requests to the new PC start the following cycle.
  - Back-to-back redirects: the last one wins and discard is recomputed each time.
- Arithmetic: all PC increments are modulo 2^XLEN, so 32'hFFFF_FFFC + 4 wraps to 0.
- Widths: count, outstanding and discard are $clog2(DEPTH+1) bits.
- Protocol errors: rvalid with outstanding == 0 is ignored and flagged by an assertion. gnt without req is ignored.

Decomposition:
- definitions_pkg gains:
  - fetch_entry_st {word_st pc; word_32ut instr}
  - a localparam INSTR_BYTES = 4 used for PC increments
- Existing word_st/word_32ut types are reused.
- One natural sub-module: fetch_fifo. It is a parametrised synchronous FIFO of fetch_entry_st with push/pop/clear and count/empty/full, and contains all queue storage and pointer wrap logic.

Test Plan:
- Reset, pc_init_i = 0x0000_1000, zero-latency memory (gnt = 1, rvalid next cycle), ready = 1. Required: addresses 0x1000, 0x1004, 0x1008 issued; pc_o sequence 0x1000, 0x1004 with matching instr; pc_next_4_o = pc_o + 4.
- Decode stalled (ready = 0), DEPTH = 4, MAX_OUTSTANDING = 2. Required: exactly 4 entries queued; imem_req_o low once count + outstanding = 4; head 0x1000 stable; releasing ready drains in order.
- Memory latency 3 cycles with 2 requests in flight, redirect_i with redirect_pc_i = 0x2002. Required: both stale responses dropped; next request address 0x2000; first output pc_o = 0x2000; no 0x1xxx PC ever appears after the redirect.
- Redirect coinciding with rvalid, and queue full. Required: queue empty next cycle; that response is discarded; discard equals the remaining outstanding count.
- pc_init_i = 0xFFFF_FFF8. Required: fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; pc_next_4_o of the 0xFFFF_FFFC entry = 0.
- rst_ni asserted low mid-stream with a redirect in the same cycle. Required: all outputs 0 and fetch restarts at pc_init_i.
